// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle ARMv4 main control sequencer.
package ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      UNKNOWN  = 4'd10
   } state_e;

   localparam int unsigned ALU_ENC_W = 2;
   localparam logic [ALU_ENC_W-1:0] ALU_ADD = 2'b00;
   localparam logic [ALU_ENC_W-1:0] ALU_SUB = 2'b01;
   localparam logic [ALU_ENC_W-1:0] ALU_AND = 2'b10;
   localparam logic [ALU_ENC_W-1:0] ALU_ORR = 2'b11;

   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_ORR = 4'b1100;
   localparam logic [3:0] CMD_CMP = 4'b1010;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU-control and flag-write decode for data-processing instructions.
module alu_decoder
   import ctrl_pkg::*;
#(
   parameter int unsigned ALUCTL_W = 2
) (
   input  logic                en,
   input  logic [5:0]          funct,
   input  logic [1:0]          op,
   output logic [ALUCTL_W-1:0] alu_ctrl,
   output logic [1:0]          flag_w,
   output logic                no_write
);

   logic [3:0] cmd;
   logic       s_bit;
   logic       unused_imm;

   assign cmd        = funct[4:1];
   assign s_bit      = funct[0];
   assign unused_imm = funct[5];

   // Unrecognised commands fall back to ADD without touching the flags.
   always_comb begin
      alu_ctrl = ALUCTL_W'(ALU_ADD);
      flag_w   = 2'b00;
      if (en) begin
         case (cmd)
            CMD_ADD: begin
               alu_ctrl = ALUCTL_W'(ALU_ADD);
               flag_w   = {s_bit, s_bit};
            end
            CMD_SUB: begin
               alu_ctrl = ALUCTL_W'(ALU_SUB);
               flag_w   = {s_bit, s_bit};
            end
            CMD_AND: begin
               alu_ctrl = ALUCTL_W'(ALU_AND);
               flag_w   = {s_bit, 1'b0};
            end
            CMD_ORR: begin
               alu_ctrl = ALUCTL_W'(ALU_ORR);
               flag_w   = {s_bit, 1'b0};
            end
            CMD_CMP: begin
               alu_ctrl = ALUCTL_W'(ALU_SUB);
               flag_w   = 2'b11;
            end
            default: begin
               alu_ctrl = ALUCTL_W'(ALU_ADD);
               flag_w   = 2'b00;
            end
         endcase
      end
   end

   // Held regardless of state so the writeback cycle sees it.
   assign no_write = (op == OP_DP) && (cmd == CMD_CMP);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control sequencer for the multicycle ARMv4 datapath; outputs decode
// combinationally from the state register and the instruction fields.
module multicycle_ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter int unsigned ALUCTL_W = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [1:0]          Op,
   input  logic [5:0]          Funct,
   input  logic [3:0]          Rd,
   input  logic                MemReady,
   output logic                IRWrite,
   output logic                AdrSrc,
   output logic                ALUSrcA,
   output logic [1:0]          ALUSrcB,
   output logic [1:0]          ResultSrc,
   output logic [ALUCTL_W-1:0] ALUControl,
   output logic                NextPC,
   output logic                PCS,
   output logic                RegW,
   output logic                NoWrite,
   output logic                MemW,
   output logic [1:0]          FlagW,
   output logic                InstrDone,
   output logic                Illegal
);

   state_e     state_q, state_d;
   logic       irw_c, npc_c, regw_c, memw_c, branch_c, done_c, illegal_c, alu_en_c;
   logic [1:0] flag_w_c;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= FETCH;
      else        state_q <= state_d;
   end

   // Next-state and per-state control decode.
   always_comb begin
      state_d   = state_q;
      irw_c     = 1'b0;
      npc_c     = 1'b0;
      regw_c    = 1'b0;
      memw_c    = 1'b0;
      branch_c  = 1'b0;
      done_c    = 1'b0;
      illegal_c = 1'b0;
      alu_en_c  = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = SRCB_REG;
      ResultSrc = RES_ALUOUT;
      case (state_q)
         FETCH: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALU;
            irw_c     = MemReady;
            npc_c     = MemReady;
            if (MemReady) state_d = DECODE;
         end
         DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALU;
            case (Op)
               OP_MEM:  state_d = MEMADR;
               OP_DP:   state_d = Funct[5] ? EXECI : EXECR;
               OP_BR:   state_d = BRANCH;
               default: state_d = UNKNOWN;
            endcase
         end
         MEMADR: begin
            ALUSrcB = SRCB_IMM;
            state_d = Funct[0] ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            AdrSrc = 1'b1;
            if (MemReady) state_d = MEMWB;
         end
         MEMWB: begin
            ResultSrc = RES_DATA;
            regw_c    = 1'b1;
            done_c    = 1'b1;
            state_d   = FETCH;
         end
         MEMWRITE: begin
            AdrSrc  = 1'b1;
            memw_c  = 1'b1;
            done_c  = 1'b1;
            state_d = FETCH;
         end
         EXECR: begin
            alu_en_c = 1'b1;
            state_d  = ALUWB;
         end
         EXECI: begin
            ALUSrcB  = SRCB_IMM;
            alu_en_c = 1'b1;
            state_d  = ALUWB;
         end
         ALUWB: begin
            regw_c  = 1'b1;
            done_c  = 1'b1;
            state_d = FETCH;
         end
         BRANCH: begin
            ALUSrcB   = SRCB_IMM;
            ResultSrc = RES_ALU;
            branch_c  = 1'b1;
            done_c    = 1'b1;
            state_d   = FETCH;
         end
         UNKNOWN: begin
            illegal_c = 1'b1;
            state_d   = UNKNOWN;
         end
         default: state_d = UNKNOWN;
      endcase
   end

   alu_decoder #(.ALUCTL_W(ALUCTL_W)) u_alu_decoder (
      .en       (alu_en_c),
      .funct    (Funct),
      .op       (Op),
      .alu_ctrl (ALUControl),
      .flag_w   (flag_w_c),
      .no_write (NoWrite)
   );

   // Strobes are held low for the whole time reset is asserted.
   assign IRWrite   = reset & irw_c;
   assign NextPC    = reset & npc_c;
   assign RegW      = reset & regw_c;
   assign MemW      = reset & memw_c;
   assign InstrDone = reset & done_c;
   assign Illegal   = reset & illegal_c;
   assign FlagW     = reset ? flag_w_c : 2'b00;
   assign PCS       = reset & (branch_c | (regw_c & (Rd == 4'hF)));

endmodule
